// File: rtl/prn_display_driver.sv
// ---------------------------------------------------------------------------
// prn_display_driver
//
// Shows the LFSR output (prn) in decimal on an 8-digit common-anode
// seven-segment display. A sequential shift-add-3 (double-dabble) converter
// turns the binary value into five BCD digits. A free-running scanner lights
// one digit at a time. Digit 7 carries the live LFSR error flag as 'E'.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   value          unsigned number to display (WIDTH bits, 4..16)
//   error          LFSR error flag, sampled live by the scan path
//   seg            segment drive, active-low, order {g,f,e,d,c,b,a}
//   anode_activate digit enable, active-low, bit i = digit i (0 rightmost)
//   conv_busy      high while a conversion is in progress
// ---------------------------------------------------------------------------
module prn_display_driver #(
  parameter int WIDTH = 8,
  parameter int COUNT = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             error,
  output logic [6:0]       seg,
  output logic [7:0]       anode_activate,
  output logic             conv_busy
);

  // A single-cycle dwell still needs a 1-bit counter.
  localparam int              CNT_W      = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(COUNT - 1);
  localparam logic [4:0]      SHIFT_LAST = 5'(WIDTH - 1);
  localparam logic [6:0]      SEG_BLANK  = 7'h7F;
  localparam logic [6:0]      SEG_E      = 7'b0000110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] last_value_r;
  logic [WIDTH-1:0] capture_r;
  logic [WIDTH-1:0] shift_r;
  logic [19:0]      scratch_r;
  logic [19:0]      scratch_adj_s;
  logic [4:0]       bit_cnt_r;
  logic [19:0]      bcd_r;
  logic             conv_busy_r;
  logic [CNT_W-1:0] scan_cnt_r;
  logic [2:0]       digit_idx_r;
  logic [6:0]       seg_r;
  logic [7:0]       anode_r;
  logic [6:0]       digit_seg_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [19:0] add3_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Active-low seven-segment pattern for one BCD digit.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Converter state register and busy flag (busy follows the next state so
  // it is registered yet aligned with SHIFT/DONE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      conv_busy_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      conv_busy_r <= (state_s != IDLE);
    end
  end

  // Converter next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (value != last_value_r) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == SHIFT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Adjusted scratch feeding the shift.
  always_comb begin
    scratch_adj_s = add3_adjust(scratch_r);
  end

  // Converter datapath: capture, shift-add-3, then an atomic display update.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_value_r <= '0;
      capture_r    <= '0;
      shift_r      <= '0;
      scratch_r    <= 20'd0;
      bit_cnt_r    <= 5'd0;
      bcd_r        <= 20'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (value != last_value_r) begin
            capture_r <= value;
            shift_r   <= value;
            scratch_r <= 20'd0;
            bit_cnt_r <= 5'd0;
          end else begin
            bit_cnt_r <= 5'd0;
          end
        end
        SHIFT: begin
          // The top scratch bit is never set for legal widths, so dropping
          // it on the shift loses nothing.
          {scratch_r, shift_r} <= {scratch_adj_s, shift_r} << 1;
          bit_cnt_r            <= bit_cnt_r + 5'd1;
        end
        DONE: begin
          bcd_r        <= scratch_r;
          last_value_r <= capture_r;
        end
        default: begin
          bit_cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Segment pattern for the digit currently selected by the scanner,
  // including leading-zero blanking and the error indicator.
  always_comb begin
    digit_seg_s = SEG_BLANK;
    case (digit_idx_r)
      3'd0: digit_seg_s = decode_digit(bcd_r[3:0]);
      3'd1: begin
        if (|bcd_r[19:4]) begin
          digit_seg_s = decode_digit(bcd_r[7:4]);
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      3'd2: begin
        if (|bcd_r[19:8]) begin
          digit_seg_s = decode_digit(bcd_r[11:8]);
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      3'd3: begin
        if (|bcd_r[19:12]) begin
          digit_seg_s = decode_digit(bcd_r[15:12]);
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      3'd4: begin
        if (|bcd_r[19:16]) begin
          digit_seg_s = decode_digit(bcd_r[19:16]);
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      3'd7: begin
        if (error) begin
          digit_seg_s = SEG_E;
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      default: digit_seg_s = SEG_BLANK;
    endcase
  end

  // Display scanner: dwell counter, digit index and registered drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r  <= '0;
      digit_idx_r <= 3'd0;
      seg_r       <= SEG_BLANK;
      anode_r     <= 8'hFF;
    end else begin
      if (scan_cnt_r == CNT_MAX) begin
        scan_cnt_r  <= '0;
        digit_idx_r <= digit_idx_r + 3'd1;
      end else begin
        scan_cnt_r  <= scan_cnt_r + 1'b1;
      end
      seg_r   <= digit_seg_s;
      anode_r <= ~(8'd1 << digit_idx_r);
    end
  end

  assign seg            = seg_r;
  assign anode_activate = anode_r;
  assign conv_busy      = conv_busy_r;

endmodule

// File: tb/tb_prn_display_driver.sv
module tb_prn_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       error;
  logic [6:0] seg1, seg3;
  logic [7:0] an1, an3;
  logic       busy1, busy3;
  int         checks = 0;
  int         fails  = 0;
  int         n;

  always #5 clk = ~clk;

  prn_display_driver #(.WIDTH(8), .COUNT(1)) dut (
    .clk(clk), .reset(reset), .value(value), .error(error),
    .seg(seg1), .anode_activate(an1), .conv_busy(busy1)
  );

  prn_display_driver #(.WIDTH(8), .COUNT(3)) dut3 (
    .clk(clk), .reset(reset), .value(value), .error(error),
    .seg(seg3), .anode_activate(an3), .conv_busy(busy3)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for digit d's slot on the COUNT=1 instance, then check seg.
  task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
    logic [7:0] tgt;
    logic       found;
    tgt   = ~(8'd1 << d);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step;
      if (an1 === tgt) found = 1'b1;
    end
    chk({tag, "_slot"}, {31'd0, found}, 32'd1);
    chk(tag, {25'd0, seg1}, {25'd0, exp});
  endtask

  // Count cycles with conv_busy high for one conversion (bounded).
  task automatic measure_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (busy1) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (busy1 === 1'b0) break;
      step;
    end
    chk(tag, {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    value = 8'd0;
    error = 1'b0;
    step;
    step;
    chk("rst_seg", {25'd0, seg1}, 32'h7F);
    chk("rst_an", {24'd0, an1}, 32'hFF);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_seg3", {25'd0, seg3}, 32'h7F);
    chk("rst_an3", {24'd0, an3}, 32'hFF);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    reset = 1'b0;

    // Idle scan with value 0: one step per cycle (COUNT=1), 3 per step (COUNT=3).
    for (int k = 1; k <= 26; k++) begin
      logic [7:0] e1, e3;
      logic [6:0] es;
      step;
      e1 = ~(8'd1 << ((k - 1) % 8));
      e3 = ~(8'd1 << (((k - 1) / 3) % 8));
      es = (((k - 1) % 8) == 0) ? 7'h40 : 7'h7F;
      chk("scan_an", {24'd0, an1}, {24'd0, e1});
      chk("scan_seg", {25'd0, seg1}, {25'd0, es});
      chk("scan_busy", {31'd0, busy1}, 32'd0);
      chk("scan_an3", {24'd0, an3}, {24'd0, e3});
    end

    // 237 held.
    value = 8'd237;
    measure_busy(n);
    chk("busy_len_237", n, 32'd9);
    check_digit(0, 7'h78, "d0_237");
    check_digit(1, 7'h30, "d1_237");
    check_digit(2, 7'h24, "d2_237");
    check_digit(3, 7'h7F, "d3_237");
    check_digit(4, 7'h7F, "d4_237");
    check_digit(5, 7'h7F, "d5_237");
    check_digit(6, 7'h7F, "d6_237");
    check_digit(7, 7'h7F, "d7_237");

    // Change 237 -> 5 in the middle of SHIFT.
    value = 8'd5;
    measure_busy(n);
    chk("busy_len_5", n, 32'd9);
    value = 8'd237;
    step;
    step;
    step;
    step;
    chk("mid_busy", {31'd0, busy1}, 32'd1);
    value = 8'd5;
    for (int i = 0; i < 40; i++) begin
      step;
      if (!busy1) break;
    end
    chk("first_done", {31'd0, busy1}, 32'd0);
    step;
    chk("restart", {31'd0, busy1}, 32'd1);
    wait_idle("restart_idle");
    check_digit(0, 7'h12, "d0_5");
    check_digit(1, 7'h7F, "d1_5");
    check_digit(2, 7'h7F, "d2_5");
    check_digit(3, 7'h7F, "d3_5");
    check_digit(4, 7'h7F, "d4_5");

    // error with 100.
    value = 8'd100;
    error = 1'b1;
    measure_busy(n);
    chk("busy_len_100", n, 32'd9);
    check_digit(0, 7'h40, "d0_100");
    check_digit(1, 7'h40, "d1_100");
    check_digit(2, 7'h79, "d2_100");
    check_digit(3, 7'h7F, "d3_100");
    check_digit(6, 7'h7F, "d6_100");
    check_digit(7, 7'h06, "d7_err");
    error = 1'b0;
    check_digit(7, 7'h7F, "d7_noerr");

    // Reset during SHIFT of 255.
    value = 8'd255;
    step;
    step;
    step;
    chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    step;
    chk("mid_rst_seg", {25'd0, seg1}, 32'h7F);
    chk("mid_rst_an", {24'd0, an1}, 32'hFF);
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rst_busy3", {31'd0, busy3}, 32'd0);
    reset = 1'b0;
    measure_busy(n);
    chk("busy_len_255", n, 32'd9);
    check_digit(0, 7'h12, "d0_255");
    check_digit(1, 7'h12, "d1_255");
    check_digit(2, 7'h24, "d2_255");
    check_digit(3, 7'h7F, "d3_255");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/prn_display_driver.md
Name: prn_display_driver

Overview:
- Downstream consumer of the Fibonacci LFSR output (prn) and error flag.
- Converts the current prn value to decimal using a sequential shift-add-3 (double-dabble) converter.
- Drives a time-multiplexed 8-digit common-anode seven-segment display (seg, anode_activate) on the board.
- Replaces direct hex display so the PRN sequence reads in decimal.

Parameters:
- WIDTH, 8, bit width of value; legal range 4..16.
- COUNT, 100000, clock cycles each digit stays lit before the scan advances; COUNT=1 for simulation, legal minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- value  input  WIDTH  unsigned number to display (prn)
- error  input  1  LFSR error flag
- seg  output  7  segment drive, active-low, order {g,f,e,d,c,b,a}
- anode_activate  output  8  digit enable, active-low, bit i = digit i (digit 0 rightmost)
- conv_busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (synchronous, active-high):
  - seg=7'h7F, anode_activate=8'hFF, conv_busy=0.
  - FSM=IDLE; last_value=0; BCD display registers=0; scan counter=0; digit index=0.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if value != last_value, capture value into shift register, clear BCD scratch (5 digits, 20 bits), go to SHIFT. Otherwise stay.
  - SHIFT: exactly WIDTH cycles. Each cycle, add 3 to every scratch BCD nibble >=5, then shift {scratch, shift_reg} left by 1. After the WIDTH-th shift, go to DONE.
  - DONE: copy scratch into the 5 display BCD registers, set last_value to the captured value, go to IDLE.
  - conv_busy=1 in SHIFT and DONE.
- Latency: value presented before edge E0 appears in the display registers at edge E0+WIDTH+1.
- value changes during SHIFT/DONE are ignored for the current conversion. The next IDLE cycle detects the mismatch and restarts, so the final display always matches the last stable value.
- value equal to last_value never triggers a conversion. Value 0 after reset shows "0" with no conversion.
- error is not converted. It is sampled live by the scan path.
- Digit content:
  - digits 0..4: BCD units..ten-thousands.
  - Leading-zero blanking: digit k (k>=1) is blank if it and all higher BCD digits are 0. Digit 0 is never blanked.
  - digits 5,6: always blank.
  - digit 7: 'E' (7'b0000110) when error=1, else blank.
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex), blank=7F.
- Scan:
  - Counter runs 0..COUNT-1. On the cycle it equals COUNT-1 it wraps to 0 and digit index increments, wrapping 7->0.
  - seg and anode_activate are registered and reflect the current index one edge later.
  - anode_activate is one-hot-low: exactly one bit low at all times after the first post-reset edge.
  - Scan runs independently of conversion. Display registers change atomically in DONE, so no digit shows a partial result.
- Reset mid-conversion aborts the conversion immediately. All state returns to reset values.
- Values of WIDTH bits up to 65535 fit 5 digits. No overflow case exists.

Test Plan:
- Reset, COUNT=1, value=0, error=0:
  - After reset, anode_activate cycles FE,FD,FB,...,7F,FE, one step per cycle.
  - seg=40 while digit 0 is lit, 7F on all others; conv_busy stays 0.
- value=8'd237 held:
  - conv_busy high for exactly WIDTH+1=9 cycles.
  - Display registers become 2,3,7 at edge 9.
  - Digits 0/1/2 show 78/30/24; digits 3..7 show 7F.
- value 237 -> 5 in the middle of SHIFT:
  - First conversion completes (237 displayed briefly).
  - A second conversion starts the cycle after DONE; final digits 0=12, 1..4 blank.
- error=1 with value=8'd100:
  - Digit 7 shows 06; digits 0..2 show 40,40,79 (zeros in 100 not blanked); digits 3..6 show 7F.
  - Drop error: digit 7 returns to 7F on its next scan slot.
- COUNT=3:
  - Each anode stays active exactly 3 cycles; a full scan is 24 cycles.
- Reset asserted during SHIFT of value 255:
  - Next edge gives seg=7F, anode_activate=FF, conv_busy=0.
  - Release with value=255: full conversion restarts; final display 5,5,2.
